// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control unit feeding a MIPS-style datapath.
// Define CTRL_PERF_EN to add the cycle_cnt / retire_cnt performance counters.
module multicycle_ctrl #(
   parameter int unsigned MEM_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        instr_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        jump,
   output logic        reg_dst,
   output logic        alu_src,
   output logic [3:0]  alu_ctrl,
   output logic        branch,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        illegal
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;

   localparam logic [3:0] MEM_LAST = 4'(MEM_CYCLES - 1);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   state_t     state, state_next;
   logic       running;
   logic [5:0] op_q, fn_q;
   logic [3:0] mem_cnt;
   logic       accept, mem_last;
   logic       dec_legal, dec_reg_dst, dec_alu_src, dec_mem_to_reg;
   logic [3:0] dec_alu_ctrl;

   // running holds instr_ready low until the first clock after reset release
   assign accept   = (state == S_FETCH) && running && instr_valid;
   assign mem_last = (mem_cnt == MEM_LAST);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      dec_legal      = 1'b1;
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_alu_ctrl   = ALU_AND;
      case (op_q)
         OP_RTYPE: begin
            dec_reg_dst = 1'b1;
            case (fn_q)
               6'b100000: dec_alu_ctrl = ALU_ADD;
               6'b100010: dec_alu_ctrl = ALU_SUB;
               6'b100100: dec_alu_ctrl = ALU_AND;
               6'b100101: dec_alu_ctrl = ALU_OR;
               6'b101010: dec_alu_ctrl = ALU_SLT;
               default:   dec_legal    = 1'b0;
            endcase
         end
         OP_ADDI: begin
            dec_alu_src  = 1'b1;
            dec_alu_ctrl = ALU_ADD;
         end
         OP_LW: begin
            dec_alu_src    = 1'b1;
            dec_alu_ctrl   = ALU_ADD;
            dec_mem_to_reg = 1'b1;
         end
         OP_SW: begin
            dec_alu_src  = 1'b1;
            dec_alu_ctrl = ALU_ADD;
         end
         OP_BEQ:  dec_alu_ctrl = ALU_SUB;
         OP_J:    ;
         default: dec_legal = 1'b0;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         running    <= 1'b0;
         op_q       <= 6'd0;
         fn_q       <= 6'd0;
         mem_cnt    <= 4'd0;
         reg_dst    <= 1'b0;
         alu_src    <= 1'b0;
         alu_ctrl   <= ALU_AND;
         mem_to_reg <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         state   <= state_next;
         running <= 1'b1;
         if (accept) begin
            op_q <= opcode;
            fn_q <= funct;
         end
         // decoded fields stay put until the next legal instruction leaves DECODE
         if (state == S_DECODE) begin
            if (dec_legal) begin
               reg_dst    <= dec_reg_dst;
               alu_src    <= dec_alu_src;
               alu_ctrl   <= dec_alu_ctrl;
               mem_to_reg <= dec_mem_to_reg;
            end else begin
               illegal <= 1'b1;
            end
         end
         if (state == S_MEM && !mem_last) mem_cnt <= mem_cnt + 4'd1;
         else                             mem_cnt <= 4'd0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (accept) state_next = S_DECODE;
         S_DECODE: state_next = dec_legal ? S_EXEC : S_FETCH;
         S_EXEC: begin
            case (op_q)
               OP_LW, OP_SW:  state_next = S_MEM;
               OP_BEQ, OP_J:  state_next = S_FETCH;
               default:       state_next = S_WB;
            endcase
         end
         S_MEM:    if (mem_last) state_next = (op_q == OP_SW) ? S_FETCH : S_WB;
         S_WB:     state_next = S_FETCH;
         default:  state_next = S_FETCH;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      case (state)
         S_FETCH: begin
            instr_ready = running;
            ir_write    = accept;
         end
         S_EXEC: begin
            if (op_q == OP_BEQ) begin
               branch   = 1'b1;
               pc_src   = 1'b1;
               pc_write = zero;
            end else if (op_q == OP_J) begin
               jump     = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_MEM: begin
            if (op_q == OP_SW) begin
               mem_write = (mem_cnt == 4'd0);
               pc_write  = mem_last;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CTRL_PERF_EN
   logic retire;
   assign retire = pc_write || (state == S_EXEC && op_q == OP_BEQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt  <= 32'd0;
         retire_cnt <= 32'd0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (retire) retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases, then random instruction
// streams compared per cycle against a latency-rule reference model.
module tb_multicycle_ctrl;

   localparam int MC = 3;

   typedef enum {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [5:0]  opcode, funct;
   logic        zero;
   logic        instr_ready, ir_write, pc_write, pc_src, jump, reg_dst, alu_src;
   logic [3:0]  alu_ctrl;
   logic        branch, mem_write, mem_to_reg, reg_write, illegal;
`ifdef CTRL_PERF_EN
   logic [31:0] cycle_cnt, retire_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic ill_exp = 1'b0;

   logic [5:0] r_fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [3:0] r_alu [5] = '{4'b0001, 4'b0011, 4'b0000, 4'b0010, 4'b0100};

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
      .zero(zero), .instr_ready(instr_ready), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .jump(jump), .reg_dst(reg_dst), .alu_src(alu_src),
      .alu_ctrl(alu_ctrl), .branch(branch), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal)
`ifdef CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] strobes();
      return {instr_ready, ir_write, pc_write, pc_src, jump, branch, mem_write, reg_write};
   endfunction

   function automatic logic [15:0] all_outs();
      return {instr_ready, ir_write, pc_write, pc_src, jump, reg_dst, alu_src, alu_ctrl,
              branch, mem_write, mem_to_reg, reg_write, illegal};
   endfunction

   function automatic logic [6:0] fields();
      return {reg_dst, alu_src, mem_to_reg, alu_ctrl};
   endfunction

   // cycles from the accept edge until FETCH is re-entered
   function automatic int latency(kind_t k);
      case (k)
         K_R, K_ADDI: return 4;
         K_LW:        return 4 + MC;
         K_SW:        return 3 + MC;
         K_BEQ, K_J:  return 3;
         default:     return 2;
      endcase
   endfunction

   // expected {instr_ready, ir_write, pc_write, pc_src, jump, branch, mem_write, reg_write}
   // in cycle n, where cycle 0 is the accepting FETCH cycle
   function automatic logic [7:0] exp_strobes(kind_t k, int n, int len, logic z);
      logic rdy, irw, pcw, pcs, jmp, br, mw, rw;
      rdy = (n == 0);
      irw = (n == 0);
      pcw = 1'b0; pcs = 1'b0; jmp = 1'b0; br = 1'b0; mw = 1'b0; rw = 1'b0;
      case (k)
         K_BEQ: if (n == 2) begin br = 1'b1; pcs = 1'b1; pcw = z; end
         K_J:   if (n == 2) begin jmp = 1'b1; pcw = 1'b1; end
         K_ILL: ;
         default: begin
            if (n == len - 1) pcw = 1'b1;
            if (k == K_SW && n == 3) mw = 1'b1;
            if (k != K_SW && n == len - 1) rw = 1'b1;
         end
      endcase
      return {rdy, irw, pcw, pcs, jmp, br, mw, rw};
   endfunction

   // {mask, value} over {reg_dst, alu_src, mem_to_reg, alu_ctrl}
   function automatic logic [13:0] exp_fields(kind_t k, logic [5:0] fn);
      logic [3:0] alu;
      alu = 4'b0000;
      case (k)
         K_R: begin
            for (int i = 0; i < 5; i++) if (r_fn[i] == fn) alu = r_alu[i];
            return {7'h7f, 3'b100, alu};
         end
         K_ADDI:  return {7'h7f, 3'b010, 4'b0001};
         K_LW:    return {7'h7f, 3'b011, 4'b0001};
         K_SW:    return {7'b0101111, 3'b010, 4'b0001};
         K_BEQ:   return {7'b0101111, 3'b000, 4'b0011};
         default: return 14'd0;
      endcase
   endfunction

   function automatic bit legal_op(logic [5:0] op);
      return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   endfunction

   function automatic bit legal_fn(logic [5:0] fn);
      for (int i = 0; i < 5; i++) if (r_fn[i] == fn) return 1'b1;
      return 1'b0;
   endfunction

`ifdef CTRL_PERF_EN
   logic [31:0] pf_c0, pf_r0;
   int          pf_len;
   logic        pf_legal;
   bit          pf_pend = 1'b0;
`endif

   task automatic perf_close();
`ifdef CTRL_PERF_EN
      if (pf_pend) begin
         check("cycle_cnt delta", cycle_cnt - pf_c0, 32'(pf_len));
         check("retire_cnt delta", retire_cnt - pf_r0, {31'd0, pf_legal});
         pf_pend = 1'b0;
      end
`endif
   endtask

   task automatic perf_open(input int len, input bit legal);
`ifdef CTRL_PERF_EN
      pf_c0 = cycle_cnt; pf_r0 = retire_cnt; pf_len = len; pf_legal = legal; pf_pend = 1'b1;
`else
      if (len < 0 && legal) $display("perf counters absent");
`endif
   endtask

   task automatic idle();
      @(negedge clk);
      instr_valid = 1'b0; opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      #1;
      perf_close();
      check("idle strobes", {24'd0, strobes()}, 32'h80);
      check("idle illegal", {31'd0, illegal}, {31'd0, ill_exp});
   endtask

   // zsel: 0/1 forces zero in EXEC, 2 randomizes it
   task automatic issue(input kind_t k, input logic [5:0] op, input logic [5:0] fn, input int zsel);
      int         len;
      logic [13:0] f;
      len = latency(k);
      f   = exp_fields(k, fn);
      @(negedge clk);
      instr_valid = 1'b1; opcode = op; funct = fn; zero = 1'($urandom);
      #1;
      perf_close();
      check($sformatf("%s c0 strobes", k.name()), {24'd0, strobes()},
            {24'd0, exp_strobes(k, 0, len, zero)});
      check($sformatf("%s c0 illegal", k.name()), {31'd0, illegal}, {31'd0, ill_exp});
      perf_open(len, k != K_ILL);
      for (int n = 1; n < len; n++) begin
         @(negedge clk);
         instr_valid = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom);
         zero = (n == 2 && zsel != 2) ? 1'(zsel) : 1'($urandom);
         #1;
         check($sformatf("%s c%0d strobes", k.name(), n), {24'd0, strobes()},
               {24'd0, exp_strobes(k, n, len, zero)});
         check($sformatf("%s c%0d illegal", k.name(), n), {31'd0, illegal}, {31'd0, ill_exp});
         if (n >= 2 && f[13:7] != 7'd0)
            check($sformatf("%s c%0d fields", k.name(), n), {25'd0, fields() & f[13:7]},
                  {25'd0, f[6:0] & f[13:7]});
      end
      if (k == K_ILL) ill_exp = 1'b1;
   endtask

   task automatic gen(output kind_t k, output logic [5:0] op, output logic [5:0] fn);
      int r;
      r  = $urandom_range(0, 19);
      fn = 6'($urandom);
      if (r < 6)       begin k = K_R;    op = 6'b000000; fn = r_fn[$urandom_range(0, 4)]; end
      else if (r < 8)  begin k = K_ADDI; op = 6'b001000; end
      else if (r < 10) begin k = K_LW;   op = 6'b100011; end
      else if (r < 12) begin k = K_SW;   op = 6'b101011; end
      else if (r < 15) begin k = K_BEQ;  op = 6'b000100; end
      else if (r < 17) begin k = K_J;    op = 6'b000010; end
      else begin
         k = K_ILL;
         if (r == 17) begin
            do op = 6'($urandom); while (legal_op(op));
         end else begin
            op = 6'b000000;
            do fn = 6'($urandom); while (legal_fn(fn));
         end
      end
   endtask

   task automatic reset_mid_add();
      @(negedge clk);
      instr_valid = 1'b1; opcode = 6'b000000; funct = 6'b100000;
      repeat (3) begin
         @(negedge clk);
         instr_valid = 1'b0;
      end
      #1;
      perf_close();
      check("pre-reset WB reg_write", {31'd0, reg_write}, 32'd1);
      rst = 1'b1;
      #1;
      check("async reset reg_write", {31'd0, reg_write}, 32'd0);
      check("async reset outputs", {16'd0, all_outs()}, 32'd0);
      @(negedge clk);
      check("held reset outputs", {16'd0, all_outs()}, 32'd0);
      rst = 1'b0;
      ill_exp = 1'b0;
`ifdef CTRL_PERF_EN
      check("reset cycle_cnt", cycle_cnt, 32'd0);
      check("reset retire_cnt", retire_cnt, 32'd0);
      pf_pend = 1'b0;
`endif
      idle();
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      kind_t      k;
      logic [5:0] op, fn;
      rst = 1'b1; instr_valid = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset outputs", {16'd0, all_outs()}, 32'd0);
      rst = 1'b0;
      idle();

      issue(K_R,    6'b000000, 6'b100000, 2);
      issue(K_ADDI, 6'b001000, 6'b000000, 2);
      issue(K_LW,   6'b100011, 6'b000000, 2);
      issue(K_SW,   6'b101011, 6'b000000, 2);
      issue(K_BEQ,  6'b000100, 6'b000000, 1);
      issue(K_BEQ,  6'b000100, 6'b000000, 0);
      issue(K_J,    6'b000010, 6'b000000, 2);
      idle();
      issue(K_ILL,  6'b111111, 6'b000000, 2);
      issue(K_ILL,  6'b000000, 6'b000111, 2);
      issue(K_R,    6'b000000, 6'b101010, 2);
      reset_mid_add();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         gen(k, op, fn);
         issue(k, op, fn, 2);
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit directly upstream of the CPU datapath; generates the datapath control pins (reg_dst, reg_write, alu_src, branch, mem_write, mem_to_reg, alu_ctrl) from a fetched instruction.
- Steps through FETCH/DECODE/EXEC/MEM/WB so control pins change only at state boundaries. This removes mid-instruction pin changes.

Parameters:
- MEM_CYCLES, 1, cycles spent in MEM state (legal range 1..15); models data-memory latency.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  fetch unit presents an instruction
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag from datapath
- instr_ready  out  1  control can accept an instruction
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- jump  out  1  select jump target
- reg_dst  out  1  1 = rd, 0 = rt
- alu_src  out  1  1 = immediate
- alu_ctrl  out  4  ALU operation
- branch  out  1  branch compare cycle
- mem_write  out  1  data-memory write strobe
- mem_to_reg  out  1  write-back from memory
- reg_write  out  1  register-file write strobe
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state = FETCH; every output 0 while rst is high, including instr_ready and illegal.
- FETCH:
  - instr_ready = 1.
  - On instr_valid & instr_ready: ir_write = 1 for that cycle, latch opcode/funct, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Register decoded fields reg_dst, alu_src, alu_ctrl, mem_to_reg. Hold them stable until the next DECODE.
  - Opcode map:
    - 000000 R-type: reg_dst = 1, alu_src = 0.
    - 001000 addi: alu_src = 1, alu_ctrl = 0001.
    - 100011 lw: alu_src = 1, ADD, mem_to_reg = 1.
    - 101011 sw: alu_src = 1, ADD.
    - 000100 beq: alu_src = 0, SUB.
    - 000010 j.
  - R-type funct map: 100000 -> 0001 ADD; 100010 -> 0011 SUB; 100100 -> 0000 AND; 100101 -> 0010 OR; 101010 -> 0100 SLT.
  - Unknown opcode or funct: set illegal (sticky until rst), emit no strobes, return to FETCH.
- EXEC (1 cycle):
  - R-type/addi -> WB.
  - lw/sw -> MEM.
  - beq: branch = 1 and pc_src = 1; pc_write = zero; -> FETCH.
  - j: jump = 1, pc_write = 1 -> FETCH.
- MEM:
  - Stay in MEM for exactly MEM_CYCLES cycles, counted with an internal 4-bit counter.
  - sw: mem_write = 1 only in the first MEM cycle, then -> FETCH.
  - lw: -> WB.
- WB (1 cycle): reg_write = 1, then -> FETCH.
- PC update for sequential instructions: pc_write = 1, pc_src = 0 in the final cycle of every non-branch, non-jump instruction (WB, or the last MEM cycle for sw).
- Strobe rule: ir_write, pc_write, branch, jump, mem_write and reg_write are single-cycle pulses. They are never high outside the states listed above.
- Latency, in cycles from the accept edge to FETCH re-entry:
  - R-type/addi: 4.
  - lw: 4 + MEM_CYCLES.
  - sw: 3 + MEM_CYCLES.
  - beq, j: 3.
  - illegal: 2.
- Handshake: instr_valid is ignored outside FETCH. An instruction arriving back-to-back is accepted on the first FETCH cycle.
- Reset mid-instruction: state returns to FETCH and strobes drop immediately (asynchronously). A pending mem_write/reg_write must not occur after rst is released.

Optional Feature:
- Macro: CTRL_PERF_EN.
- When defined, adds two 32-bit outputs:
  - cycle_cnt: increments every cycle out of reset.
  - retire_cnt: increments on each completed legal instruction, i.e. the cycle pc_write is high or a beq exits EXEC.
  - Both counters reset to 0 and wrap at 2^32.
- When not defined, neither port nor its logic exists.

Test Plan:
- Reset: rst = 1 mid-WB of an add -> reg_write drops asynchronously; all outputs 0; after release, instr_ready = 1 on the next cycle.
- add (opcode 000000, funct 100000) -> DECODE gives reg_dst = 1, alu_src = 0, alu_ctrl = 0001; reg_write pulse exactly 3 cycles after the accept edge; instr_ready high again at cycle 4.
- addi (opcode 001000) -> alu_src = 1, reg_dst = 0, alu_ctrl = 0001, single reg_write pulse.
- lw then sw with MEM_CYCLES = 3:
  - lw: mem_to_reg = 1, reg_write at cycle 6.
  - sw: exactly one mem_write pulse at cycle 3, reg_write never set, FETCH at cycle 6.
- beq with zero = 1 -> branch = 1, pc_src = 1, pc_write = 1 in EXEC. Repeat with zero = 0 -> pc_write stays 0. Both return to FETCH at cycle 3.
- Illegal opcode 111111, then funct 000111 -> illegal set and stays 1; no strobes fire. With CTRL_PERF_EN, retire_cnt unchanged while cycle_cnt advances.
